// File: rtl/fsm_spw.sv
// fsm_spw: SpaceWire link-interface state machine sequencing receiver reset and transmitter modes
//  pclk/resetn         clock, asynchronous active-low reset
//  link_start          host start request (level)
//  auto_start          host auto-start on received NULL (level)
//  link_disable        host force link down (level, dominates start)
//  rx_error            receiver parity/escape error pulse
//  rx_got_bit          receiver bit strobe
//  rx_got_null/fct/nchar/time_code  receiver decoded-event pulses
//  rx_resetn           receiver reset, active-low
//  enable_tx           transmitter enabled
//  send_null_tx        transmitter may send NULLs
//  send_fct_tx         transmitter may send FCTs
//  fsm_state           0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started, 4 Connecting, 5 Run
module fsm_spw #(
  parameter int T_6U4   = 640,
  parameter int T_12U8  = 1280,
  parameter int T_DISC  = 85,
  parameter int TIMER_W = 12
) (
  input  logic       pclk,
  input  logic       resetn,
  input  logic       link_start,
  input  logic       auto_start,
  input  logic       link_disable,
  input  logic       rx_error,
  input  logic       rx_got_bit,
  input  logic       rx_got_null,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic       rx_got_time_code,
  output logic       rx_resetn,
  output logic       enable_tx,
  output logic       send_null_tx,
  output logic       send_fct_tx,
  output logic [2:0] fsm_state
);
  localparam int DISC_W = $clog2(T_DISC + 1);
  typedef enum logic [2:0] {
    S_ERR_RESET  = 3'd0,
    S_ERR_WAIT   = 3'd1,
    S_READY      = 3'd2,
    S_STARTED    = 3'd3,
    S_CONNECTING = 3'd4,
    S_RUN        = 3'd5
  } state_t;
  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [DISC_W-1:0]   disc_q, disc_d;
  logic                got_null_q, got_null_d;
  logic                bit_seen_q, bit_seen_d;
  logic                rx_resetn_q, rx_resetn_d;
  logic                enable_tx_q, enable_tx_d;
  logic                send_fct_q, send_fct_d;
  logic                disc_err, err_any, ctl_err, t6_done, t12_done, in_reset;
  always_comb begin
    in_reset = state_q == S_ERR_RESET;
    t6_done  = timer_q == TIMER_W'(T_6U4 - 1);
    t12_done = timer_q == TIMER_W'(T_12U8 - 1);
    disc_err = bit_seen_q && disc_q >= DISC_W'(T_DISC);
    err_any  = rx_error | disc_err;
    ctl_err  = err_any | rx_got_fct | rx_got_nchar | rx_got_time_code;
    state_d  = S_ERR_RESET;
    case (state_q)
      S_ERR_RESET:  state_d = t6_done ? S_ERR_WAIT : S_ERR_RESET;
      S_ERR_WAIT:   state_d = ctl_err ? S_ERR_RESET : t12_done ? S_READY : S_ERR_WAIT;
      S_READY:      state_d = ctl_err ? S_ERR_RESET :
                              (!link_disable && (link_start || (auto_start && got_null_q))) ? S_STARTED : S_READY;
      S_STARTED:    state_d = (ctl_err || t12_done) ? S_ERR_RESET : got_null_q ? S_CONNECTING : S_STARTED;
      // FCT is the advancing event here, so it is excluded from the error set.
      S_CONNECTING: state_d = (err_any || rx_got_nchar || rx_got_time_code || t12_done) ? S_ERR_RESET :
                              rx_got_fct ? S_RUN : S_CONNECTING;
      S_RUN:        state_d = (err_any || link_disable) ? S_ERR_RESET : S_RUN;
      default:      state_d = S_ERR_RESET;
    endcase
    timer_d     = state_d != state_q ? '0 : &timer_q ? timer_q : timer_q + 1'b1;
    got_null_d  = in_reset ? 1'b0 : got_null_q | rx_got_null;
    bit_seen_d  = in_reset ? 1'b0 : bit_seen_q | rx_got_bit;
    disc_d      = (in_reset || rx_got_bit) ? '0 : &disc_q ? disc_q : disc_q + 1'b1;
    // Outputs follow the next state so they switch together with fsm_state.
    rx_resetn_d = state_d != S_ERR_RESET;
    enable_tx_d = state_d inside {S_STARTED, S_CONNECTING, S_RUN};
    send_fct_d  = state_d inside {S_CONNECTING, S_RUN};
  end
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_ERR_RESET;
      timer_q     <= '0;
      disc_q      <= '0;
      got_null_q  <= 1'b0;
      bit_seen_q  <= 1'b0;
      rx_resetn_q <= 1'b0;
      enable_tx_q <= 1'b0;
      send_fct_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      disc_q      <= disc_d;
      got_null_q  <= got_null_d;
      bit_seen_q  <= bit_seen_d;
      rx_resetn_q <= rx_resetn_d;
      enable_tx_q <= enable_tx_d;
      send_fct_q  <= send_fct_d;
    end
  end
  assign rx_resetn    = rx_resetn_q;
  assign enable_tx    = enable_tx_q;
  assign send_null_tx = enable_tx_q;
  assign send_fct_tx  = send_fct_q;
  assign fsm_state    = state_q;
endmodule

// File: tb/tb_fsm_spw.sv
// tb_fsm_spw: self-checking bench for fsm_spw with vector table and expected-output queue
module tb_fsm_spw;
  logic pclk = 1'b0;
  logic resetn = 1'b0;
  logic link_start, auto_start, link_disable, rx_error, rx_got_bit;
  logic rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code;
  logic rx_resetn, enable_tx, send_null_tx, send_fct_tx;
  logic [2:0] fsm_state;
  int checks = 0;
  int failures = 0;
  localparam logic [8:0] LS = 9'h100, AS = 9'h080, LD = 9'h040, ER = 9'h020, BT = 9'h010;
  localparam logic [8:0] NU = 9'h008, FC = 9'h004, NC = 9'h002, TC = 9'h001;
  typedef struct {
    logic [2:0] start;
    logic [8:0] in;
    logic [2:0] exp;
  } vec_t;
  typedef struct {
    string      name;
    logic [6:0] exp;
  } sb_t;
  sb_t  sbq[$];
  vec_t tbl[19];
  always #5 pclk = ~pclk;
  fsm_spw dut (
    .pclk(pclk), .resetn(resetn), .link_start(link_start), .auto_start(auto_start),
    .link_disable(link_disable), .rx_error(rx_error), .rx_got_bit(rx_got_bit),
    .rx_got_null(rx_got_null), .rx_got_fct(rx_got_fct), .rx_got_nchar(rx_got_nchar),
    .rx_got_time_code(rx_got_time_code), .rx_resetn(rx_resetn), .enable_tx(enable_tx),
    .send_null_tx(send_null_tx), .send_fct_tx(send_fct_tx), .fsm_state(fsm_state)
  );
  function automatic logic [6:0] model(input logic [2:0] s);
    return {s, s != 3'd0, s >= 3'd3, s >= 3'd3, s >= 3'd4};
  endfunction
  function automatic logic [6:0] obs();
    return {fsm_state, rx_resetn, enable_tx, send_null_tx, send_fct_tx};
  endfunction
  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got state/rx_resetn/en/null/fct=%b expected %b", name, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      @(negedge pclk);
    end
  endtask
  task automatic expect_state(input string name, input logic [2:0] s);
    sbq.push_back('{name, model(s)});
  endtask
  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.name, obs(), e.exp);
    end
  endtask
  task automatic drive(input logic [8:0] v);
    {link_start, auto_start, link_disable, rx_error, rx_got_bit,
     rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code} = v;
  endtask
  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    for (int i = 0; i < budget && fsm_state != s; i++) step(1);
    chk(name, obs(), model(s));
  endtask
  task automatic bring_to(input logic [2:0] s);
    drive(9'h0);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    wait_state("reach_ready", 3'd2, 2000);
    if (s >= 3'd3) begin
      drive(LS); step(1); drive(9'h0);
      wait_state("reach_started", 3'd3, 2);
    end
    if (s >= 3'd4) begin
      drive(NU); step(1); drive(9'h0);
      wait_state("reach_connecting", 3'd4, 3);
    end
    if (s >= 3'd5) begin
      drive(FC); step(1); drive(9'h0);
      wait_state("reach_run", 3'd5, 2);
    end
  endtask
  task automatic boot_seq(input string tag);
    expect_state({tag, "_er_639"}, 3'd0); step(639); drain();
    expect_state({tag, "_ew_640"}, 3'd1); step(1); drain();
    expect_state({tag, "_ew_1919"}, 3'd1); step(1279); drain();
    expect_state({tag, "_rdy_1920"}, 3'd2); step(1); drain();
    expect_state({tag, "_rdy_held"}, 3'd2); step(50); drain();
  endtask
  initial begin
    tbl[0]  = '{3'd2, LS,           3'd3};
    tbl[1]  = '{3'd2, LS | LD,      3'd2};
    tbl[2]  = '{3'd2, AS,           3'd2};
    tbl[3]  = '{3'd2, FC,           3'd0};
    tbl[4]  = '{3'd2, ER | LS,      3'd0};
    tbl[5]  = '{3'd2, NU | BT,      3'd2};
    tbl[6]  = '{3'd3, NU,           3'd3};
    tbl[7]  = '{3'd3, NC,           3'd0};
    tbl[8]  = '{3'd3, LD,           3'd3};
    tbl[9]  = '{3'd3, NU | ER,      3'd0};
    tbl[10] = '{3'd4, FC,           3'd5};
    tbl[11] = '{3'd4, FC | NC,      3'd0};
    tbl[12] = '{3'd4, TC,           3'd0};
    tbl[13] = '{3'd4, NC,           3'd0};
    tbl[14] = '{3'd4, LD,           3'd4};
    tbl[15] = '{3'd5, FC | NC | TC, 3'd5};
    tbl[16] = '{3'd5, LD,           3'd0};
    tbl[17] = '{3'd5, ER,           3'd0};
    tbl[18] = '{3'd5, NU | BT,      3'd5};
    drive(9'h0);
    @(negedge pclk);
    chk("reset_hold", obs(), model(3'd0));
    step(2);
    chk("reset_hold_clk", obs(), model(3'd0));
    resetn = 1'b1;
    boot_seq("boot");
    drive(LS);
    expect_state("start_started", 3'd3); step(1); drain();
    step(9);
    drive(LS | NU); step(1); drive(LS);
    expect_state("start_connecting", 3'd4); step(1); drain();
    step(19);
    drive(LS | FC); expect_state("start_run", 3'd5); step(1); drain();
    drive(9'h0);
    expect_state("run_hold", 3'd5); step(5); drain();
    for (int i = 0; i < 19; i++) begin
      bring_to(tbl[i].start);
      drive(tbl[i].in);
      expect_state($sformatf("vec%0d", i), tbl[i].exp);
      step(1);
      drive(9'h0);
      drain();
    end
    drive(9'h0);
    resetn = 1'b0; step(1); resetn = 1'b1;
    step(700);
    drive(AS | NU); step(1); drive(AS);
    expect_state("auto_ready", 3'd2); step(1219); drain();
    expect_state("auto_started", 3'd3); step(1); drain();
    drive(9'h0);
    bring_to(3'd4);
    expect_state("conn_timeout_1279", 3'd4); step(1279); drain();
    expect_state("conn_timeout", 3'd0); step(1); drain();
    bring_to(3'd5);
    drive(BT); step(1); drive(9'h0);
    expect_state("disc_84", 3'd5); step(84); drain();
    expect_state("disc_85", 3'd5); step(1); drain();
    expect_state("disc_err", 3'd0); step(1); drain();
    bring_to(3'd5);
    #2 resetn = 1'b0;
    #1 chk("async_reset", obs(), model(3'd0));
    @(negedge pclk);
    step(3);
    chk("async_reset_hold", obs(), model(3'd0));
    resetn = 1'b1;
    boot_seq("reboot");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
